demux_scheduler: RTL

Credit-based dispatch controller that sequences the 4-way 32-bit output demultiplexer. It accepts words from a single upstream valid/ready stream into a one-entry holding register, chooses an output lane, and drives the demultiplexer's `data_in`/`sel`/`enable` for exactly one cycle per word. A lane is chosen round-robin or by an explicit destination. Each lane is flow-controlled by credits returned from its consumer.

---
 rtl/demux_scheduler.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/demux_scheduler.sv
// demux_scheduler: credit-based dispatch controller for a 4-way 32-bit output demux.
// Accepts one word at a time into a holding register. It picks an output lane either
// round-robin or from an explicit destination, then drives the demux for one cycle.
// Optional per-lane dispatch counters are enabled by defining DEMUX_SCHED_STATS_EN.
module demux_scheduler #(
   parameter int unsigned CREDITS = 4,
   parameter int unsigned CW      = $clog2(CREDITS + 1)
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   input  logic [1:0]  in_dest,
   input  logic        mode,
   input  logic [3:0]  credit_ret,
   output logic [31:0] demux_data,
   output logic [1:0]  demux_sel,
   output logic        demux_en,
   output logic [3:0]  lane_valid,
   output logic        credit_err,
   output logic [63:0] lane_count
);

   typedef enum logic [1:0] {IDLE, ARB, SEND} state_t;

   state_t        state;
   logic [31:0]   hold_data;
   logic [1:0]    hold_dest;
   logic          hold_mode;
   logic [1:0]    last_grant;
   logic [CW-1:0] credit [4];

   logic [3:0]    elig_c;
   logic          gnt_ok_c;
   logic [1:0]    gnt_lane_c;
   logic [3:0]    dec_c;

   // A lane is eligible whenever it holds at least one credit
   always_comb begin
      elig_c = '0;
      for (int i = 0; i < 4; i++) begin
         elig_c[i] = (credit[i] != '0);
      end
   end

   // Lane choice: the latched destination, or the first eligible lane after last_grant
   always_comb begin
      logic [1:0] idx;
      gnt_ok_c   = 1'b0;
      gnt_lane_c = '0;
      idx        = '0;
      if (hold_mode) begin
         if (elig_c[hold_dest]) begin
            gnt_ok_c   = 1'b1;
            gnt_lane_c = hold_dest;
         end
      end else begin
         for (int k = 1; k <= 4; k++) begin
            idx = last_grant + 2'(k);
            if (!gnt_ok_c && elig_c[idx]) begin
               gnt_ok_c   = 1'b1;
               gnt_lane_c = idx;
            end
         end
      end
   end

   // Credit decrement strobe, only when a grant is actually taken in ARB
   always_comb begin
      dec_c = '0;
      if (state == ARB && gnt_ok_c) begin
         dec_c[gnt_lane_c] = 1'b1;
      end
   end

   // Per-lane credit counters with saturation at CREDITS and a sticky overflow flag
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            credit[i] <= CW'(CREDITS);
         end
         credit_err <= 1'b0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            case ({dec_c[i], credit_ret[i]})
               2'b10: credit[i] <= credit[i] - CW'(1);
               2'b01: begin
                  if (credit[i] == CW'(CREDITS)) begin
                     credit_err <= 1'b1;
                  end else begin
                     credit[i] <= credit[i] + CW'(1);
                  end
               end
               default: credit[i] <= credit[i];
            endcase
         end
      end
   end

   // Dispatch FSM; demux outputs are loaded on grant so they are live only during SEND
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         in_ready   <= 1'b1;
         hold_data  <= '0;
         hold_dest  <= '0;
         hold_mode  <= 1'b0;
         last_grant <= 2'd3;
         demux_en   <= 1'b0;
         demux_sel  <= '0;
         demux_data <= '0;
         lane_valid <= '0;
      end else begin
         demux_en   <= 1'b0;
         demux_sel  <= '0;
         demux_data <= '0;
         lane_valid <= '0;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  hold_data <= in_data;
                  hold_dest <= in_dest;
                  hold_mode <= mode;
                  in_ready  <= 1'b0;
                  state     <= ARB;
               end
            end
            ARB: begin
               if (gnt_ok_c) begin
                  last_grant <= gnt_lane_c;
                  demux_en   <= 1'b1;
                  demux_sel  <= gnt_lane_c;
                  demux_data <= hold_data;
                  lane_valid <= 4'b0001 << gnt_lane_c;
                  state      <= SEND;
               end
            end
            SEND: begin
               in_ready <= 1'b1;
               state    <= IDLE;
            end
            default: begin
               in_ready <= 1'b1;
               state    <= IDLE;
            end
         endcase
      end
   end

`ifdef DEMUX_SCHED_STATS_EN
   logic [15:0] cnt [4];

   // Wrapping 16-bit dispatch counter per lane, bumped at the end of each SEND
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            cnt[i] <= '0;
         end
      end else if (state == SEND && demux_en) begin
         cnt[demux_sel] <= cnt[demux_sel] + 16'd1;
      end
   end

   assign lane_count = {cnt[3], cnt[2], cnt[1], cnt[0]};
`else
   assign lane_count = '0;
`endif

endmodule
